// File: rtl/range_stream_pkg.sv
// ============================================================================
// range_stream_pkg : shared types and default sizes for range_stream_tx
// Rev 1.0
// ============================================================================
`default_nettype none

package range_stream_pkg;
  localparam int DEF_WIDTH = 10;
  localparam int DEF_DEPTH = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;
endpackage

`default_nettype wire

// File: rtl/range_stream_tx_if.sv
// ============================================================================
// range_stream_tx_if : host load/start controls plus framed stream outputs
// Rev 1.0
// ============================================================================
`default_nettype none

interface range_stream_tx_if
  import range_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  logic                     clear;
  logic                     wr_en;
  logic [WIDTH-1:0]         wr_data;
  logic                     start;
  logic [WIDTH-1:0]         tx_data;
  logic                     tx_go;
  logic                     tx_finish;
  logic                     busy;
  logic                     done;
  logic                     err;
  logic [$clog2(DEPTH):0]   count;
  logic [WIDTH-1:0]         exp_range;

  modport master (
    output clear, wr_en, wr_data, start,
    input  tx_data, tx_go, tx_finish, busy, done, err, count, exp_range
  );

  modport slave (
    input  clear, wr_en, wr_data, start,
    output tx_data, tx_go, tx_finish, busy, done, err, count, exp_range
  );
endinterface

`default_nettype wire

// File: rtl/range_tx_buffer.sv
// ============================================================================
// range_tx_buffer : DEPTH x WIDTH register file, one write port, async read
// Rev 1.0
// ============================================================================
`default_nettype none

module range_tx_buffer
  import range_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  wire logic             clock,
  input  wire logic             we,
  input  wire logic [AW-1:0]    waddr,
  input  wire logic [WIDTH-1:0] wdata,
  input  wire logic [AW-1:0]    raddr,
  output logic      [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

`default_nettype wire

// File: rtl/range_stream_tx.sv
// ============================================================================
// range_stream_tx : replays a loaded burst with go/finish framing and tracks
//                   the max-min range of the loaded words. Rev 1.0
// ============================================================================
`default_nettype none

module range_stream_tx
  import range_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input wire logic         clock,
  input wire logic         reset,
  range_stream_tx_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  tx_state_t        state;
  logic [AW-1:0]    idx;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] min_q, max_q, new_min, new_max;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] tx_data_q, range_q;
  logic             go_q, fin_q, busy_q, done_q, err_q;
  logic             full, accept, wr_ok, last;

  assign full    = (count_q == CW'(DEPTH));
  assign accept  = (state == IDLE) && bus.start && (count_q >= CW'(2));
  assign wr_ok   = (state == IDLE) && bus.wr_en && !bus.start && !bus.clear && !full;
  assign last    = ({1'b0, idx} == count_q - CW'(1));
  // In SEND, prefetch the word that follows the one currently on tx_data.
  assign rd_addr = (state == SEND) ? idx + AW'(1) : '0;

  assign new_min = (count_q == '0 || bus.wr_data < min_q) ? bus.wr_data : min_q;
  assign new_max = (count_q == '0 || bus.wr_data > max_q) ? bus.wr_data : max_q;

  range_tx_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_buf (
    .clock (clock),
    .we    (wr_ok),
    .waddr (count_q[AW-1:0]),
    .wdata (bus.wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clock) begin
    if (reset || bus.clear) begin
      state     <= IDLE;
      idx       <= '0;
      count_q   <= '0;
      min_q     <= '0;
      max_q     <= '0;
      range_q   <= '0;
      tx_data_q <= '0;
      go_q      <= 1'b0;
      fin_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            if (accept) begin
              state     <= SEND;
              idx       <= '0;
              tx_data_q <= rd_data;
              go_q      <= 1'b1;
              fin_q     <= 1'b0;
              busy_q    <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end else if (bus.wr_en) begin
            if (full) begin
              err_q <= 1'b1;
            end else begin
              count_q <= count_q + CW'(1);
              min_q   <= new_min;
              max_q   <= new_max;
              range_q <= new_max - new_min;
            end
          end
        end
        SEND: begin
          if (last) begin
            state     <= IDLE;
            tx_data_q <= '0;
            go_q      <= 1'b0;
            fin_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            idx       <= idx + AW'(1);
            tx_data_q <= rd_data;
            go_q      <= 1'b0;
            fin_q     <= ({1'b0, idx} + CW'(2) == count_q);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx_data   = tx_data_q;
  assign bus.tx_go     = go_q;
  assign bus.tx_finish = fin_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.count     = count_q;
  assign bus.exp_range = range_q;
endmodule

`default_nettype wire

// File: tb/tb_range_stream_tx.sv
// ============================================================================
// tb_range_stream_tx : directed bench with a queue-based behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_range_stream_tx;
  localparam int W = 10;
  localparam int D = 8;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  bit   armed = 0;

  range_stream_tx_if #(.WIDTH(W), .DEPTH(D)) bus ();
  range_stream_tx #(.WIDTH(W), .DEPTH(D)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  // Model: the loaded words, the stream position (-1 when not streaming), sticky err, done pulse.
  int q[$];
  int pos    = -1;
  bit m_err  = 0;
  bit m_done = 0;

  always @(posedge clock) begin
    if (reset || bus.clear) begin
      q.delete();
      pos = -1; m_err = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (pos >= 0) begin
        if (pos == q.size() - 1) begin pos = -1; m_done = 1; end
        else pos++;
      end else if (bus.start) begin
        if (q.size() >= 2) pos = 0; else m_err = 1;
      end else if (bus.wr_en) begin
        if (q.size() < D) q.push_back(int'(bus.wr_data)); else m_err = 1;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (armed) begin
      int mn, mx;
      mn = 0; mx = 0;
      foreach (q[i]) begin
        if (i == 0 || q[i] < mn) mn = q[i];
        if (i == 0 || q[i] > mx) mx = q[i];
      end
      check("busy",      int'(bus.busy),      int'(pos >= 0));
      check("tx_go",     int'(bus.tx_go),     int'(pos == 0));
      check("tx_finish", int'(bus.tx_finish), int'(pos >= 0 && pos == q.size() - 1));
      check("tx_data",   int'(bus.tx_data),   (pos >= 0) ? q[pos] : 0);
      check("done",      int'(bus.done),      int'(m_done));
      check("err",       int'(bus.err),       int'(m_err));
      check("count",     int'(bus.count),     q.size());
      check("exp_range", int'(bus.exp_range), mx - mn);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input int v);
    bus.wr_en   = 1'b1;
    bus.wr_data = W'(v);
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  initial begin
    int big[8];
    big = '{100, 5, 700, 33, 1000, 2, 64, 512};
    reset = 1'b1;
    bus.clear = 1'b0; bus.wr_en = 1'b0; bus.wr_data = '0; bus.start = 1'b0;
    tick();
    armed = 1;
    tick();
    reset = 1'b0;
    check("reset_count", int'(bus.count), 0);
    check("reset_busy",  int'(bus.busy),  0);

    // Basic burst 3,9,5,1
    load(3); load(9); load(5); load(1);
    check("t1_count", int'(bus.count), 4);
    check("t1_range", int'(bus.exp_range), 8);
    pulse_start();
    check("t1_go",    int'(bus.tx_go), 1);
    check("t1_data0", int'(bus.tx_data), 3);
    tick(); check("t1_data1", int'(bus.tx_data), 9);
    tick(); check("t1_data2", int'(bus.tx_data), 5);
    tick(); check("t1_fin",   int'(bus.tx_finish), 1);
    check("t1_data3", int'(bus.tx_data), 1);
    tick(); check("t1_done",  int'(bus.done), 1);
    check("t1_err", int'(bus.err), 0);
    tick(); check("t1_done_pulse", int'(bus.done), 0);
    // Replay of the retained buffer
    pulse_start();
    check("replay_go", int'(bus.tx_data), 3);
    repeat (5) tick();

    // Overflow then clear
    pulse_clear();
    foreach (big[i]) load(big[i]);
    load(1023);
    check("t2_count", int'(bus.count), 8);
    check("t2_err",   int'(bus.err), 1);
    check("t2_range", int'(bus.exp_range), 998);
    pulse_start();
    repeat (9) tick();
    pulse_clear();
    check("t2_clr_count", int'(bus.count), 0);
    check("t2_clr_err",   int'(bus.err), 0);
    check("t2_clr_range", int'(bus.exp_range), 0);

    // Short start
    load(7);
    pulse_start();
    check("t3_err",  int'(bus.err), 1);
    check("t3_busy", int'(bus.busy), 0);
    repeat (3) tick();

    // Back-to-back start in the done cycle
    pulse_clear();
    load(2); load(4);
    pulse_start();
    tick();
    tick();
    check("t4_done", int'(bus.done), 1);
    pulse_start();
    check("t4_go2",   int'(bus.tx_go), 1);
    check("t4_data2", int'(bus.tx_data), 2);
    tick();
    check("t4_fin2",  int'(bus.tx_data), 4);
    repeat (2) tick();

    // Clear mid-burst
    pulse_clear();
    load(1); load(2); load(3); load(4);
    pulse_start();
    tick(); tick();
    check("t5_third", int'(bus.tx_data), 3);
    pulse_clear();
    check("t5_busy", int'(bus.busy), 0);
    check("t5_fin",  int'(bus.tx_finish), 0);
    tick();
    check("t5_nodone", int'(bus.done), 0);

    // wr_en with start, wr_en during SEND
    load(6); load(11);
    bus.wr_en = 1'b1; bus.wr_data = W'(99); bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.wr_data = W'(55);
    tick();
    bus.wr_en = 1'b0;
    check("t6_fin",   int'(bus.tx_finish), 1);
    check("t6_count", int'(bus.count), 2);
    tick();
    check("t6_err",   int'(bus.err), 0);
    check("t6_range", int'(bus.exp_range), 5);
    repeat (3) tick();

    armed = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
